oam_dma: RTL and testbench

Sprite-DMA bus master that sits between the CPU's bus outputs and the memory/PPU bus. A CPU write to $4014 with page value P stalls the CPU via `rdy`. The block then copies the 256 bytes at $PP00–$PPFF to the PPU OAM data port at $2004 using alternating read/write cycles, and returns the bus to the CPU. When idle it is a transparent pass-through for the CPU's address, data and R_nW.

---
 rtl/nes_pkg.sv | 16 +
 rtl/oam_dma.sv | 101 ++++++++++
 tb/tb_oam_dma.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared NES bus constants and the sprite-DMA state encoding, also used by
// the CPU-side memory decoder.
package nes_pkg;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite-DMA bus master: a CPU write to $4014 stalls the CPU and copies one
// 256-byte page to the PPU OAM data port, otherwise it passes the CPU bus through.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = nes_pkg::OAMDMA_ADDR,
  parameter logic [15:0] OAMDATA_ADDR = nes_pkg::OAMDATA_ADDR
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_r_nw,
  input  logic [7:0]  mem_data_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_r_nw,
  output logic        rdy,
  output logic        dma_active
);

  dma_state_t state;
  dma_state_t state_next;

  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] latch;
  logic       odd;
  logic       trigger;

  assign trigger = (cpu_addr == TRIGGER_ADDR) && !cpu_r_nw;

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Parity runs freely from reset so READ can be pinned to even cycles.
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      page  <= 8'h00;
      idx   <= 8'h00;
      latch <= 8'h00;
      odd   <= 1'b0;
    end else begin
      odd <= ~odd;
      case (state)
        IDLE: begin
          if (trigger) begin
            page <= cpu_data_out;
            idx  <= 8'h00;
          end
        end
        READ:    latch <= mem_data_in;
        WRITE:   idx   <= idx + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    mem_addr     = cpu_addr;
    mem_data_out = cpu_data_out;
    mem_r_nw     = cpu_r_nw;
    case (state)
      IDLE: begin
        if (trigger) state_next = HALT;
      end
      HALT: begin
        if (cpu_r_nw) state_next = odd ? READ : ALIGN;
      end
      ALIGN: begin
        mem_addr     = {page, 8'h00};
        mem_data_out = latch;
        mem_r_nw     = 1'b1;
        state_next   = READ;
      end
      READ: begin
        mem_addr     = {page, idx};
        mem_data_out = latch;
        mem_r_nw     = 1'b1;
        state_next   = WRITE;
      end
      WRITE: begin
        mem_addr     = OAMDATA_ADDR;
        mem_data_out = latch;
        mem_r_nw     = 1'b0;
        state_next   = (idx == 8'hFF) ? IDLE : READ;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rdy        = (state == IDLE);
  assign dma_active = (state == ALIGN) || (state == READ) || (state == WRITE);

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: pass-through vector table, randomized bus traffic and
// full page transfers checked against a simple memory/OAM reference model.
module tb_oam_dma;

  localparam logic [15:0] TRIG  = 16'h4014;
  localparam logic [15:0] OAMD  = 16'h2004;
  localparam logic [15:0] PARK  = 16'h8000;

  logic        clk_ph1 = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_r_nw;
  logic [7:0]  mem_data_in;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic        mem_r_nw;
  logic        rdy;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  logic        tb_odd = 1'b0;

  int compared = 0;
  int mismatched = 0;

  bit          mon_en = 1'b0;
  int          rdy_low_cnt;
  int          dma_cnt;
  logic [23:0] wr_q [$];
  logic [16:0] rd_q [$];

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        r_nw;
    logic [15:0] exp_addr;
    logic [7:0]  exp_dout;
    logic        exp_r_nw;
    logic        exp_rdy;
  } vec_t;

  oam_dma dut (
    .clk_ph1      (clk_ph1),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_r_nw     (cpu_r_nw),
    .mem_data_in  (mem_data_in),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_r_nw     (mem_r_nw),
    .rdy          (rdy),
    .dma_active   (dma_active)
  );

  always #5 clk_ph1 = ~clk_ph1;

  assign mem_data_in = mem[mem_addr];

  // Reference cycle parity: cleared by reset, toggles on every other edge.
  always @(posedge clk_ph1) tb_odd <= !rst ? 1'b0 : ~tb_odd;

  always @(negedge clk_ph1) begin
    #2;
    if (mon_en) begin
      if (rdy === 1'b0) rdy_low_cnt++;
      if (dma_active === 1'b1) begin
        dma_cnt++;
        if (mem_r_nw === 1'b0) wr_q.push_back({mem_addr, mem_data_out});
        else rd_q.push_back({tb_odd, mem_addr});
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    @(negedge clk_ph1);
    cpu_addr     = a;
    cpu_data_out = d;
    cpu_r_nw     = rnw;
    #1;
  endtask

  // One complete DMA: trigger on a cycle chosen so HALT parity gives the
  // requested alignment, optionally inject a $4014 write or reset mid-way.
  task automatic run_transfer(input logic [7:0] p, input bit a, input bit inject, input int reset_at);
    int c;
    bit done;
    logic [15:0] exp_rd [$];
    @(negedge clk_ph1);
    while (tb_odd !== a) @(negedge clk_ph1);
    cpu_addr = TRIG; cpu_r_nw = 1'b0; cpu_data_out = p;
    @(negedge clk_ph1);
    wr_q.delete(); rd_q.delete();
    rdy_low_cnt = 0; dma_cnt = 0; mon_en = 1'b1;
    cpu_addr = PARK; cpu_r_nw = 1'b1; cpu_data_out = 8'h00;
    c = 1; done = 1'b0;
    while (!done && c < 800) begin
      @(negedge clk_ph1);
      c++;
      if (inject && c == 10) begin
        cpu_addr = TRIG; cpu_r_nw = 1'b0; cpu_data_out = ~p;
      end else begin
        cpu_addr = PARK; cpu_r_nw = 1'b1; cpu_data_out = 8'h00;
      end
      if (reset_at > 0 && c == reset_at) begin
        rst = 1'b0;
        @(negedge clk_ph1);
        rst = 1'b1;
        #3;
        mon_en = 1'b0;
        check_output("rst_mid_rdy", {31'd0, rdy}, 32'd1);
        check_output("rst_mid_active", {31'd0, dma_active}, 32'd0);
        check_output("rst_mid_idx", {24'd0, dut.idx}, 32'd0);
        check_output("rst_mid_addr", {16'd0, mem_addr}, {16'd0, PARK});
        check_output("rst_mid_rnw", {31'd0, mem_r_nw}, 32'd1);
        check_output("rst_mid_writes", wr_q.size(), 32'd101);
        if (wr_q.size() > 0)
          check_output("rst_mid_last", {8'd0, wr_q[$]}, {8'd0, OAMD, mem[{p, 8'd100}]});
        return;
      end
      #3;
      if (rdy === 1'b1) done = 1'b1;
    end
    mon_en = 1'b0;
    check_output("xfer_done", {31'd0, done}, 32'd1);
    check_output("rdy_low_cycles", rdy_low_cnt, 513 + a);
    check_output("active_cycles", dma_cnt, 512 + a);
    check_output("write_count", wr_q.size(), 32'd256);
    for (int k = 0; k < 256 && k < wr_q.size(); k++)
      check_output($sformatf("oam_write[%0d]", k), {8'd0, wr_q[k]}, {8'd0, OAMD, mem[{p, k[7:0]}]});
    if (a) exp_rd.push_back({p, 8'h00});
    for (int k = 0; k < 256; k++) exp_rd.push_back({p, k[7:0]});
    check_output("read_count", rd_q.size(), exp_rd.size());
    for (int j = 0; j < exp_rd.size() && j < rd_q.size(); j++) begin
      check_output($sformatf("read_addr[%0d]", j), {16'd0, rd_q[j][15:0]}, {16'd0, exp_rd[j]});
      if (j >= int'(a)) check_output($sformatf("read_even[%0d]", j), {31'd0, rd_q[j][16]}, 32'd0);
    end
    check_output("after_xfer_addr", {16'd0, mem_addr}, {16'd0, PARK});
    check_output("after_xfer_active", {31'd0, dma_active}, 32'd0);
  endtask

  vec_t vecs [5];

  initial begin
    logic [15:0] ra;
    logic [7:0]  rd;
    logic        rw;
    vecs[0] = '{16'h00F0, 8'h11, 1'b1, 16'h00F0, 8'h11, 1'b1, 1'b1};
    vecs[1] = '{16'h4015, 8'hA5, 1'b0, 16'h4015, 8'hA5, 1'b0, 1'b1};
    vecs[2] = '{16'h4014, 8'h03, 1'b1, 16'h4014, 8'h03, 1'b1, 1'b1};
    vecs[3] = '{16'h00F0, 8'h00, 1'b1, 16'h00F0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{16'h4013, 8'h7E, 1'b0, 16'h4013, 8'h7E, 1'b0, 1'b1};

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    rst = 1'b0; cpu_addr = 16'h1234; cpu_data_out = 8'hC3; cpu_r_nw = 1'b1;
    @(negedge clk_ph1);
    @(negedge clk_ph1);
    #1;
    check_output("reset_rdy", {31'd0, rdy}, 32'd1);
    check_output("reset_active", {31'd0, dma_active}, 32'd0);
    check_output("reset_addr", {16'd0, mem_addr}, 32'h1234);
    check_output("reset_dout", {24'd0, mem_data_out}, 32'hC3);
    check_output("reset_page", {24'd0, dut.page}, 32'd0);
    check_output("reset_latch", {24'd0, dut.latch}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].addr, vecs[i].dout, vecs[i].r_nw);
      check_output($sformatf("vec%0d_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].exp_addr});
      check_output($sformatf("vec%0d_dout", i), {24'd0, mem_data_out}, {24'd0, vecs[i].exp_dout});
      check_output($sformatf("vec%0d_rnw", i), {31'd0, mem_r_nw}, {31'd0, vecs[i].exp_r_nw});
      check_output($sformatf("vec%0d_rdy", i), {31'd0, rdy}, {31'd0, vecs[i].exp_rdy});
    end

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rd = 8'($urandom);
      rw = 1'($urandom);
      if (ra == TRIG) ra = 16'h4015;
      apply_stimulus(ra, rd, rw);
      check_output("rand_pass_addr", {16'd0, mem_addr}, {16'd0, ra});
      check_output("rand_pass_dout", {24'd0, mem_data_out}, {24'd0, rd});
      check_output("rand_pass_rnw", {31'd0, mem_r_nw}, {31'd0, rw});
      check_output("rand_pass_rdy", {31'd0, rdy}, 32'd1);
    end

    run_transfer(8'h02, 1'b0, 1'b0, 0);
    run_transfer(8'h02, 1'b1, 1'b0, 0);
    run_transfer(8'h37, 1'($urandom), 1'b1, 0);
    run_transfer(8'hFF, 1'b0, 1'b0, 0);
    run_transfer(8'h10, 1'b1, 1'b0, 204);
    run_transfer(8'h11, 1'b0, 1'b0, 203);
    for (int i = 0; i < 2; i++) run_transfer(8'($urandom), 1'($urandom), 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
